// File: rtl/pc_unit_if.sv
// Control and status bundle between the datapath and the program-counter unit.
// The datapath side drives the control inputs; the PC unit drives the status outputs.
interface pc_unit_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
);
   // Control, datapath -> PC unit
   logic             stall_i;
   logic             redirect_i;
   logic [XLEN-1:0]  redirect_target_i;
   logic             trap_i;
   logic             halt_i;
   logic             resume_i;

   // Status, PC unit -> datapath
   logic [XLEN-1:0]  pc_o;
   logic [XLEN-1:0]  pc_plus_o;
   logic             pc_valid_o;
   logic             misalign_o;
   logic [XLEN-1:0]  bad_addr_o;
   logic [CNT_W-1:0] fetch_cnt_o;
   logic [1:0]       state_o;

   modport master (
      output stall_i,
      output redirect_i,
      output redirect_target_i,
      output trap_i,
      output halt_i,
      output resume_i,
      input  pc_o,
      input  pc_plus_o,
      input  pc_valid_o,
      input  misalign_o,
      input  bad_addr_o,
      input  fetch_cnt_o,
      input  state_o
   );

   modport slave (
      input  stall_i,
      input  redirect_i,
      input  redirect_target_i,
      input  trap_i,
      input  halt_i,
      input  resume_i,
      output pc_o,
      output pc_plus_o,
      output pc_valid_o,
      output misalign_o,
      output bad_addr_o,
      output fetch_cnt_o,
      output state_o
   );
endinterface

// File: rtl/pc_unit.sv
// Program counter for the single-cycle RV32 core: PC register, PC+STEP adder,
// boot cycle, stall, redirect with alignment check, trap entry, halt/resume and
// a saturating fetch counter.
module pc_unit #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
   parameter int unsigned     STEP      = 4,
   parameter int unsigned     IALIGN    = 32,
   parameter int unsigned     CNT_W     = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   pc_unit_if.slave    bus
);

   typedef enum logic [1:0] {
      StBoot = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2
   } state_e;

   // Low address bits that must be zero in a legal redirect target.
   localparam logic [XLEN-1:0] AlignMask = XLEN'(IALIGN / 8 - 1);
   localparam logic [XLEN-1:0] StepVal   = XLEN'(STEP);
   localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

   state_e           state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  bad_addr_q, bad_addr_d;
   logic             misalign_q, misalign_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [XLEN-1:0]  pc_plus;
   logic             target_misaligned;

   // Sequential increment wraps naturally modulo 2^XLEN.
   assign pc_plus           = pc_q + StepVal;
   assign target_misaligned = (bus.redirect_target_i & AlignMask) != '0;

   // Next-state logic: boot sequencing, PC selection by priority, counter.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      bad_addr_d = bad_addr_q;
      misalign_d = 1'b0;
      cnt_d      = cnt_q;

      case (state_q)
         StBoot: begin
            // Inputs ignored; PC stays at the reset vector.
            state_d = StRun;
         end

         StRun: begin
            // Counts every issued PC, including redirect/trap/halt cycles.
            if (!bus.stall_i && (cnt_q != CntMax)) begin
               cnt_d = cnt_q + 1'b1;
            end

            if (bus.trap_i) begin
               pc_d = TRAP_VEC;
            end else if (bus.redirect_i) begin
               if (target_misaligned) begin
                  pc_d       = TRAP_VEC;
                  bad_addr_d = bus.redirect_target_i;
                  misalign_d = 1'b1;
               end else begin
                  pc_d = bus.redirect_target_i;
               end
            end else if (bus.halt_i) begin
               state_d = StHalt;
            end else if (!bus.stall_i) begin
               pc_d = pc_plus;
            end
         end

         StHalt: begin
            // Stall and redirect are ignored; trap wins over resume.
            if (bus.trap_i) begin
               pc_d    = TRAP_VEC;
               state_d = StRun;
            end else if (bus.resume_i) begin
               state_d = StRun;
            end
         end

         default: begin
            state_d = StBoot;
            pc_d    = RESET_VEC;
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StBoot;
         pc_q       <= RESET_VEC;
         bad_addr_q <= '0;
         misalign_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         bad_addr_q <= bad_addr_d;
         misalign_q <= misalign_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.pc_o        = pc_q;
   assign bus.pc_plus_o   = pc_plus;
   assign bus.pc_valid_o  = (state_q == StRun);
   assign bus.misalign_o  = misalign_q;
   assign bus.bad_addr_o  = bad_addr_q;
   assign bus.fetch_cnt_o = cnt_q;
   assign bus.state_o     = state_q;

endmodule
